// File: rtl/bcd_to_binary_seq_pkg.sv
// Purpose: shared types, constants and input-range helper for the BCD-to-binary converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_to_binary_seq_pkg;

  // FSM encoding; values are fixed so they read back the same in waveforms.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of shift/correct iterations: one per result bit.
  localparam int N_ITER = 8;

  // Largest decimal value that fits the 8-bit result.
  localparam int MAX_VAL = 255;

  // Width of the iteration counter and the count value of the final iteration.
  localparam int             CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  // Width of the BCD part of the working register: 2-bit hundreds + two nibbles.
  localparam int BCD_W = 10;
  localparam int BIN_W = 8;
  localparam int SR_W  = BCD_W + BIN_W;

  // True when the digit triple cannot be converted: a non-decimal nibble,
  // hundreds = 3, or a decimal value above MAX_VAL. The sum is formed in
  // 10 bits so anything up to 299 (and even the raw worst case 465) compares
  // without wrapping.
  function automatic logic bcd_invalid(input logic [1:0] h,
                                       input logic [3:0] t,
                                       input logic [3:0] o);
    logic [9:0] val;
    val = 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
    return (t > 4'd9) || (o > 4'd9) || (h == 2'd3) || (val > 10'(MAX_VAL));
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Purpose: request/result bundle of the BCD-to-binary converter.
// Latency: n/a (wires only).
// Backpressure: none; requests made while the converter is busy are dropped.
//
// Signals:
//   start              conversion request (master -> slave)
//   HUNDREDS/TENS/ONES BCD digits (master -> slave)
//   bin                8-bit result (slave -> master)
//   busy/done/err      status (slave -> master)
interface bcd_to_binary_seq_if;
  logic       start;
  logic [1:0] HUNDREDS;
  logic [3:0] TENS;
  logic [3:0] ONES;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  // Requester side.
  modport master (
    output start, HUNDREDS, TENS, ONES,
    input  bin, busy, done, err
  );

  // Converter side.
  modport slave (
    input  start, HUNDREDS, TENS, ONES,
    output bin, busy, done, err
  );
endinterface

// File: rtl/bcd_to_binary_seq_sub3.sv
// Purpose: per-nibble correction step of reverse double-dabble (mirror of add3).
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   din   4-bit nibble after the right shift
//   dout  din - 3 when din is 8..12, otherwise din unchanged
module sub3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // After a right shift a BCD nibble can only land in 0..12. A value of 8 or
  // more means a tens-weight bit (worth 10/2 = 5 here) dropped in where the
  // binary weight is 8, so it is over by 3.
  always_comb begin
    dout = din;
    if (din >= 4'd8 && din <= 4'd12) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Purpose: sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// Latency: done 9 edges after an accepted start (1 edge for invalid digits); one start per 10 cycles.
// Backpressure: start is honoured only in IDLE; starts while busy are dropped, not queued.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset; aborts any conversion in flight
//   bus     slave side of bcd_to_binary_seq_if (start, digits in; bin, busy, done, err out)
module bcd_to_binary_seq (
  input  logic                clk,
  input  logic                resetn,
  bcd_to_binary_seq_if.slave  bus
);
  import bcd_to_binary_seq_pkg::*;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   sr;          // {hundreds[1:0], tens[3:0], ones[3:0], bin[7:0]}
  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   sr_step;
  logic [BIN_W-1:0]  bin_q;
  logic              err_q;
  logic              accept;
  logic              in_bad;
  logic              last_iter;

  logic [3:0]        o_fix;
  logic [3:0]        t_fix;
  logic [3:0]        h_fix;
  logic              unused_h_hi;

  // Request qualification
  assign accept    = (state == IDLE) && bus.start;
  assign in_bad    = bcd_invalid(bus.HUNDREDS, bus.TENS, bus.ONES);
  assign last_iter = (cnt == CNT_LAST);

  // One iteration: shift the whole register right, then correct each digit.
  assign shifted = {1'b0, sr[SR_W-1:1]};

  sub3 u_sub3_ones (
    .din  (shifted[11:8]),
    .dout (o_fix)
  );

  sub3 u_sub3_tens (
    .din  (shifted[15:12]),
    .dout (t_fix)
  );

  // The hundreds field is only 2 bits wide, so after the shift it is at most 1
  // and the correction never fires; it is kept for a uniform datapath.
  sub3 u_sub3_hund (
    .din  ({2'b00, shifted[17:16]}),
    .dout (h_fix)
  );

  // Upper bits of the hundreds correction are structurally zero.
  assign unused_h_hi = ^h_fix[3:2];

  assign sr_step = {h_fix[1:0], t_fix, o_fix, shifted[BIN_W-1:0]};

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          // Bad digits skip the iterations and report straight away.
          next_state = in_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: iteration counter, working register, held result and error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      sr    <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      // Counter only advances during SHIFT and wraps 7 -> 0 on the last pass,
      // so it is already zero for the next conversion.
      if (state == SHIFT) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (accept) begin
        // Digits are captured here; later input changes cannot reach the
        // conversion because only sr feeds the datapath.
        sr    <= in_bad ? '0 : {bus.HUNDREDS, bus.TENS, bus.ONES, {BIN_W{1'b0}}};
        bin_q <= '0;
        err_q <= in_bad;
      end else if (state == SHIFT) begin
        sr <= sr_step;
        if (last_iter) begin
          bin_q <= sr_step[BIN_W-1:0];
        end
      end
    end
  end

  // Outputs
  assign bus.bin  = bin_q;
  assign bus.err  = err_q;
  assign bus.busy = (state == SHIFT) || (state == DONE);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  bcd_to_binary_seq_if bus ();

  bcd_to_binary_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the digits.
  function automatic void model(input int h, input int t, input int o,
                                output int val, output bit invalid);
    val     = h * 100 + t * 10 + o;
    invalid = (t > 9) || (o > 9) || (h == 3) || (val > 255);
  endfunction

  // One start pulse; measure the edge count to done (the k-th negedge after the
  // accepting edge is the sample just before edge k) and check the result.
  task automatic run_conv(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                          input string tag);
    int         exp_val;
    bit         exp_bad;
    int         k_done;
    logic [7:0] bin_at;
    logic       err_at;
    model(int'(h), int'(t), int'(o), exp_val, exp_bad);
    @(negedge clk);
    bus.HUNDREDS = h;
    bus.TENS     = t;
    bus.ONES     = o;
    bus.start    = 1'b1;
    @(posedge clk);
    k_done = 0;
    bin_at = 'x;
    err_at = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.HUNDREDS = 2'($urandom);
      bus.TENS     = 4'($urandom);
      bus.ONES     = 4'($urandom);
      if (bus.done === 1'b1) begin
        k_done = k;
        bin_at = bus.bin;
        err_at = bus.err;
        break;
      end
    end
    check({tag, ".latency"}, k_done, exp_bad ? 1 : 9);
    check({tag, ".bin"}, bin_at, exp_bad ? 0 : exp_val);
    check({tag, ".err"}, err_at, exp_bad);
    @(negedge clk);
    check({tag, ".idle"}, {bus.busy, bus.done}, 0);
    check({tag, ".hold"}, {bus.err, bus.bin}, {exp_bad, 8'(exp_bad ? 0 : exp_val)});
  endtask

  initial begin
    int         v;
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    bit         seen;
    bit         busy_ok;
    int         k_done;
    int         ndone;
    logic [7:0] bin_at;
    int         pos [3];

    total        = 0;
    bad          = 0;
    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.HUNDREDS = 2'd0;
    bus.TENS     = 4'd0;
    bus.ONES     = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.out", {bus.bin, bus.busy, bus.done, bus.err}, 0);
    @(posedge clk);
    #2 resetn = 1'b1;

    // Directed values; the first one also confirms acceptance on the first edge after release.
    run_conv(2'd2, 4'd5, 4'd5, "d255");
    run_conv(2'd0, 4'd0, 4'd0, "d000");
    run_conv(2'd1, 4'd2, 4'd8, "d128");
    run_conv(2'd2, 4'd5, 4'd6, "d256");
    run_conv(2'd0, 4'hA, 4'd0, "d0A0");
    run_conv(2'd3, 4'd0, 4'd0, "d300");
    run_conv(2'd0, 4'd0, 4'hF, "d00F");
    run_conv(2'd2, 4'd9, 4'd9, "d299");

    // Randomized digits, mostly legal values with some raw nibble noise.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        v = $urandom_range(0, 255);
        h = 2'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
      end else begin
        h = 2'($urandom_range(0, 3));
        t = 4'($urandom_range(0, 15));
        o = 4'($urandom_range(0, 15));
      end
      run_conv(h, t, o, $sformatf("rnd%0d", i));
    end

    // Second start during SHIFT with new digits is ignored.
    @(negedge clk);
    bus.HUNDREDS = 2'd1; bus.TENS = 4'd0; bus.ONES = 4'd0; bus.start = 1'b1;
    @(posedge clk);
    busy_ok = 1'b1; k_done = 0; ndone = 0; bin_at = 'x;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      bus.start = (k == 4);
      if (k == 1) begin
        bus.HUNDREDS = 2'd2; bus.TENS = 4'd0; bus.ONES = 4'd0;
      end
      if (k <= 9 && bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (k_done == 0) begin
          k_done = k;
          bin_at = bus.bin;
        end
      end
    end
    check("ignore.latency", k_done, 9);
    check("ignore.bin", bin_at, 8'h64);
    check("ignore.busy", busy_ok, 1);
    check("ignore.ndone", ndone, 1);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.HUNDREDS = 2'd0; bus.TENS = 4'd9; bus.ONES = 4'd9; bus.start = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort.out", {bus.bin, bus.busy, bus.done, bus.err}, 0);
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort.nodone", seen, 0);
    @(posedge clk);
    #2 resetn = 1'b1;
    run_conv(2'd0, 4'd4, 4'd2, "post_rst");

    // start held high for 30 edges: one conversion every 10 cycles.
    @(negedge clk);
    bus.HUNDREDS = 2'd0; bus.TENS = 4'd1; bus.ONES = 4'd7; bus.start = 1'b1;
    ndone = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 30) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        check($sformatf("held.bin%0d", ndone), bus.bin, 8'h11);
        if (ndone < 3) pos[ndone] = k;
        ndone++;
      end
    end
    check("held.ndone", ndone, 3);
    check("held.pos0", pos[0], 9);
    check("held.pos1", pos[1], 19);
    check("held.pos2", pos[2], 29);
    @(negedge clk);
    check("held.idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
